// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the register-file write path.
//   REG_ADDR_W : register address width (32 architectural registers)
//   DATA_W     : register data width
//   REG_ZERO   : hard-wired zero register, never tracked as pending
//   wsel_e     : which requester currently owns the register-file write port
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      WSEL_NONE,
      WSEL_WB,
      WSEL_MD,
      WSEL_DBG
   } wsel_e;

endpackage

// File: rtl/reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
// One pending bit per register r1..r31, marking results still owed by the
// multiply/divide unit.
//   clk, reset    : clock, asynchronous active-high reset
//   set_en        : mul/div issue request (accepted only when issue_ok)
//   set_addr      : issue destination; also the issue_ok lookup address
//   clr_en        : mul/div result handshake this cycle
//   clr_addr      : register being written by that handshake
//   rs_addr       : decode source register 1 lookup
//   rt_addr       : decode source register 2 lookup
//   issue_ok      : set_addr has no outstanding mul/div write
//   hazard_stall  : a decode source register is pending
// ----------------------------------------------------------------------------
module reg_scoreboard
   import cpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   output logic                  issue_ok,
   output logic                  hazard_stall
);

   logic [31:1] pending_reg;
   logic [31:1] pending_next;
   logic [31:0] pending_vec;
   logic        set_fire;

   // r0 never has a pending bit; padding bit 0 with a constant zero lets
   // every lookup index the full 5-bit address directly.
   assign pending_vec = {pending_reg, 1'b0};

   // Lookups use the registered state only: a same-cycle clear does not
   // release an issue or a stall until the result sits in the register file.
   assign issue_ok     = (set_addr == REG_ZERO) || !pending_vec[set_addr];
   assign hazard_stall = ((rs_addr != REG_ZERO) && pending_vec[rs_addr]) ||
                         ((rt_addr != REG_ZERO) && pending_vec[rt_addr]);

   assign set_fire = set_en && issue_ok && (set_addr != REG_ZERO);

   // Set has priority over clear: a new issue landing on the same register
   // as a completing result leaves the newer op outstanding.
   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_bit
         assign pending_next[gi] =
            (set_fire && (set_addr == REG_ADDR_W'(gi))) ? 1'b1 :
            (clr_en   && (clr_addr == REG_ADDR_W'(gi))) ? 1'b0 :
                                                          pending_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wport_arbiter
// Shares the single register-file write port between pipeline writeback,
// the multi-cycle mul/div unit and the debug loader, and tracks mul/div
// destinations so decode can stall on operands not yet written.
//   clk, reset                      : clock, asynchronous active-high reset
//   wb_en, wb_addr, wb_data         : writeback, top priority, no ready
//   md_valid, md_addr, md_data      : mul/div result request
//   md_ready                        : mul/div result accepted this cycle
//   dbg_valid, dbg_addr, dbg_data   : debug loader request
//   dbg_ready                       : debug write accepted this cycle
//   md_issue, md_issue_addr         : mul/div op issued with this destination
//   issue_ok                        : destination has no outstanding write
//   rs_addr, rt_addr                : decode source registers
//   hazard_stall                    : a source register is still owed
//   pipe_hold                       : pipeline must freeze WB this cycle
//   rf_we, rf_waddr, rf_wdata       : register-file write port
// ----------------------------------------------------------------------------
module regfile_wport_arbiter
   import cpu_pkg::*;
#(
   parameter int STARVE_MAX = 4
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  md_valid,
   input  logic [REG_ADDR_W-1:0] md_addr,
   input  logic [DATA_W-1:0]     md_data,
   output logic                  md_ready,
   input  logic                  dbg_valid,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0]     dbg_data,
   output logic                  dbg_ready,
   input  logic                  md_issue,
   input  logic [REG_ADDR_W-1:0] md_issue_addr,
   output logic                  issue_ok,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   output logic                  hazard_stall,
   output logic                  pipe_hold,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   wsel_e      wsel;
   logic       md_hs;
   logic [3:0] starve_cnt_reg;
   logic [3:0] starve_cnt_next;

   // Fixed-priority grant. Reset is folded in here so that every handshake
   // output drops the moment reset asserts, without waiting for a clock.
   always_comb begin
      wsel = WSEL_NONE;
      if (!reset) begin
         if (wb_en) begin
            wsel = WSEL_WB;
         end else if (md_valid) begin
            wsel = WSEL_MD;
         end else if (dbg_valid) begin
            wsel = WSEL_DBG;
         end
      end
   end

   assign md_ready  = (wsel == WSEL_MD);
   assign dbg_ready = (wsel == WSEL_DBG);
   assign md_hs     = md_valid && md_ready;

   // Write-port mux; address/data are zeroed when nobody is granted.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = REG_ZERO;
      rf_wdata = '0;
      case (wsel)
         WSEL_WB: begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
         end
         WSEL_MD: begin
            rf_we    = 1'b1;
            rf_waddr = md_addr;
            rf_wdata = md_data;
         end
         WSEL_DBG: begin
            rf_we    = 1'b1;
            rf_waddr = dbg_addr;
            rf_wdata = dbg_data;
         end
         default: begin
            rf_we    = 1'b0;
         end
      endcase
   end

   // Counts consecutive cycles a mul/div result has waited. Once it reaches
   // the limit, pipe_hold forces WB off so mul/div is granted that cycle.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!md_valid || md_hs) begin
         starve_cnt_next = 4'd0;
      end else if (starve_cnt_reg < STARVE_LIM) begin
         starve_cnt_next = starve_cnt_reg + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt_reg <= 4'd0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
      end
   end

   assign pipe_hold = !reset && md_valid && (starve_cnt_reg == STARVE_LIM);

   reg_scoreboard u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .set_en       (md_issue),
      .set_addr     (md_issue_addr),
      .clr_en       (md_hs),
      .clr_addr     (md_addr),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .issue_ok     (issue_ok),
      .hazard_stall (hazard_stall)
   );

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wport_arbiter
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural model (pending set as a 32-bit mask, wait counter as an int)
// predicts every output; one process compares on each falling edge.
// ----------------------------------------------------------------------------
module tb_regfile_wport_arbiter;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        md_valid;
   logic [4:0]  md_addr;
   logic [31:0] md_data;
   logic        md_ready;
   logic        dbg_valid;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        dbg_ready;
   logic        md_issue;
   logic [4:0]  md_issue_addr;
   logic        issue_ok;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic        hazard_stall;
   logic        pipe_hold;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   regfile_wport_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk           (clk),
      .reset         (reset),
      .wb_en         (wb_en),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .md_valid      (md_valid),
      .md_addr       (md_addr),
      .md_data       (md_data),
      .md_ready      (md_ready),
      .dbg_valid     (dbg_valid),
      .dbg_addr      (dbg_addr),
      .dbg_data      (dbg_data),
      .dbg_ready     (dbg_ready),
      .md_issue      (md_issue),
      .md_issue_addr (md_issue_addr),
      .issue_ok      (issue_ok),
      .rs_addr       (rs_addr),
      .rt_addr       (rt_addr),
      .hazard_stall  (hazard_stall),
      .pipe_hold     (pipe_hold),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] pend;          // bit n set: r<n> owed by mul/div
   int          starve;        // cycles the current md request has waited
   logic        md_hs_last;    // md handshake at the previous edge
   logic        dbg_hs_last;

   function automatic logic [31:0] next_pend(input logic [31:0] p);
      logic [31:0] n  = p;
      logic        ok = (md_issue_addr == 5'd0) || !p[md_issue_addr];
      if (!wb_en && md_valid) n[md_addr] = 1'b0;
      if (md_issue && ok && md_issue_addr != 5'd0) n[md_issue_addr] = 1'b1;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pend        <= '0;
         starve      <= 0;
         md_hs_last  <= 1'b0;
         dbg_hs_last <= 1'b0;
      end else begin
         pend        <= next_pend(pend);
         starve      <= (!md_valid || !wb_en) ? 0 : ((starve < SMAX) ? starve + 1 : SMAX);
         md_hs_last  <= !wb_en && md_valid;
         dbg_hs_last <= !wb_en && !md_valid && dbg_valid;
      end
   end

   // ---------------- per-cycle comparison ----------------
   int          e_sel;
   logic [4:0]  e_addr;
   logic [31:0] e_data;

   always @(negedge clk) begin
      e_sel = reset ? 0 : wb_en ? 1 : md_valid ? 2 : dbg_valid ? 3 : 0;
      e_addr = (e_sel == 1) ? wb_addr : (e_sel == 2) ? md_addr : (e_sel == 3) ? dbg_addr : 5'd0;
      e_data = (e_sel == 1) ? wb_data : (e_sel == 2) ? md_data : (e_sel == 3) ? dbg_data : 32'd0;
      check("rf_we",     32'(rf_we),     32'(e_sel != 0));
      check("rf_waddr",  32'(rf_waddr),  32'(e_addr));
      check("rf_wdata",  rf_wdata,       e_data);
      check("md_ready",  32'(md_ready),  32'(e_sel == 2));
      check("dbg_ready", 32'(dbg_ready), 32'(e_sel == 3));
      check("issue_ok",  32'(issue_ok),
            32'(md_issue_addr == 5'd0 || !pend[md_issue_addr]));
      check("hazard_stall", 32'(hazard_stall),
            32'((rs_addr != 5'd0 && pend[rs_addr]) || (rt_addr != 5'd0 && pend[rt_addr])));
      check("pipe_hold", 32'(pipe_hold), 32'(!reset && md_valid && starve == SMAX));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      wb_en = 0; wb_addr = 0; wb_data = 0;
      md_valid = 0; md_addr = 0; md_data = 0;
      dbg_valid = 0; dbg_addr = 0; dbg_data = 0;
      md_issue = 0; md_issue_addr = 0;
      rs_addr = 0; rt_addr = 0;
   endtask

   int md_wait;

   initial begin
      reset = 1'b1;
      idle();
      md_valid = 1; md_addr = 5'd2; md_data = 32'h5;
      #3;
      check("rst_md_ready", 32'(md_ready), 0);
      check("rst_rf_we", 32'(rf_we), 0);
      check("rst_issue_ok", 32'(issue_ok), 1);
      tick();
      reset = 1'b0;
      idle();

      // Arbitration: WB, then mul/div, then debug.
      wb_en = 1; wb_addr = 5'd3; wb_data = 32'h11;
      md_valid = 1; md_addr = 5'd5; md_data = 32'h22;
      dbg_valid = 1; dbg_addr = 5'd7; dbg_data = 32'h33;
      @(negedge clk);
      check("arb_wb_we", 32'(rf_we), 1);
      check("arb_wb_addr", 32'(rf_waddr), 3);
      check("arb_wb_mdrdy", 32'(md_ready), 0);
      check("arb_wb_dbgrdy", 32'(dbg_ready), 0);
      tick(); wb_en = 0;
      @(negedge clk);
      check("arb_md_addr", 32'(rf_waddr), 5);
      check("arb_md_rdy", 32'(md_ready), 1);
      tick(); md_valid = 0;
      @(negedge clk);
      check("arb_dbg_addr", 32'(rf_waddr), 7);
      check("arb_dbg_rdy", 32'(dbg_ready), 1);
      tick(); idle();

      // Scoreboard lifecycle on r8.
      md_issue = 1; md_issue_addr = 5'd8;
      @(negedge clk);
      check("sb_issue_ok", 32'(issue_ok), 1);
      tick(); rs_addr = 5'd8;
      @(negedge clk);
      check("sb_stall", 32'(hazard_stall), 1);
      check("sb_reissue_ok", 32'(issue_ok), 0);
      tick(); md_issue = 0; md_valid = 1; md_addr = 5'd8; md_data = 32'hABCD;
      @(negedge clk);
      check("sb_stall_hs", 32'(hazard_stall), 1);
      check("sb_hs_rdy", 32'(md_ready), 1);
      tick(); md_valid = 0;
      @(negedge clk);
      check("sb_stall_clr", 32'(hazard_stall), 0);
      tick(); idle();

      // Starvation: WB held every cycle, hold appears in the 5th cycle.
      for (int i = 1; i <= 5; i++) begin
         wb_en = 1; wb_addr = 5'd1; wb_data = 32'(i);
         md_valid = 1; md_addr = 5'd10; md_data = 32'h77;
         @(negedge clk);
         check("starve_hold", 32'(pipe_hold), 32'(i == 5));
         if (i < 5) tick();
      end
      wb_en = 0;
      #1;
      check("starve_md_rdy", 32'(md_ready), 1);
      check("starve_md_addr", 32'(rf_waddr), 10);
      tick(); wb_en = 1;
      @(negedge clk);
      check("starve_cleared", 32'(pipe_hold), 0);
      check("starve_model_cnt", 32'(starve), 0);
      tick(); idle();

      // r0 handling.
      md_issue = 1; md_issue_addr = 5'd0;
      @(negedge clk);
      check("r0_issue_ok", 32'(issue_ok), 1);
      tick(); md_issue = 0; md_valid = 1; md_addr = 5'd0; md_data = 32'h99;
      @(negedge clk);
      check("r0_stall", 32'(hazard_stall), 0);
      check("r0_md_rdy", 32'(md_ready), 1);
      check("r0_we", 32'(rf_we), 1);
      tick(); idle();

      // Same-cycle set/clear on r9: issue while still pending is ignored.
      md_issue = 1; md_issue_addr = 5'd9;
      tick(); md_valid = 1; md_addr = 5'd9;
      @(negedge clk);
      check("sc_issue_ok", 32'(issue_ok), 0);
      tick(); idle(); rs_addr = 5'd9;
      @(negedge clk);
      check("sc_cleared", 32'(hazard_stall), 0);
      md_issue = 1; md_issue_addr = 5'd9;
      tick(); md_issue = 0; md_valid = 1; md_addr = 5'd9;
      tick(); md_valid = 0; md_issue = 1; md_issue_addr = 5'd9;
      @(negedge clk);
      check("sc_later_ok", 32'(issue_ok), 1);
      tick(); md_issue = 0;
      @(negedge clk);
      check("sc_later_pend", 32'(hazard_stall), 1);
      // Set wins: r11 not pending, handshake and issue together.
      md_issue = 1; md_issue_addr = 5'd11; md_valid = 1; md_addr = 5'd11;
      tick(); idle(); rt_addr = 5'd11;
      @(negedge clk);
      check("sc_set_wins", 32'(hazard_stall), 1);
      md_valid = 1; md_addr = 5'd11;
      tick(); md_addr = 5'd9;
      tick(); idle();

      // Asynchronous reset mid-operation.
      md_issue = 1; md_issue_addr = 5'd4;
      tick(); md_issue_addr = 5'd12;
      tick(); md_issue = 0;
      wb_en = 1; wb_addr = 5'd1; md_valid = 1; md_addr = 5'd4; md_data = 32'h44;
      rs_addr = 5'd4; rt_addr = 5'd12;
      tick(); tick(); tick();
      check("rm_pre_stall", 32'(hazard_stall), 1);
      check("rm_model_cnt", 32'(starve), 3);
      #1 reset = 1'b1;
      #1;
      check("rm_stall", 32'(hazard_stall), 0);
      check("rm_hold", 32'(pipe_hold), 0);
      check("rm_we", 32'(rf_we), 0);
      check("rm_md_rdy", 32'(md_ready), 0);
      md_issue_addr = 5'd4;
      #1;
      check("rm_issue_ok", 32'(issue_ok), 1);
      tick(); reset = 1'b0; wb_en = 0;
      #1;
      check("rm_post_rdy", 32'(md_ready), 1);
      check("rm_post_addr", 32'(rf_waddr), 4);
      tick(); idle();

      // Randomized traffic obeying the requester protocols.
      md_wait = 0;
      for (int c = 0; c < 2000; c++) begin
         tick();
         if (md_hs_last) begin
            check("md_latency", 32'(md_wait <= SMAX), 1);
            md_wait = 0;
            md_valid = 0;
         end else if (md_valid) begin
            md_wait++;
         end
         if (dbg_hs_last) dbg_valid = 0;
         if (!md_valid && $urandom_range(3) == 0) begin
            logic [4:0] q[$];
            for (int r = 1; r < 32; r++) if (pend[r]) q.push_back(5'(r));
            md_valid = 1;
            md_addr  = (q.size() > 0) ? q[$urandom_range(q.size() - 1)] : 5'($urandom_range(31));
            md_data  = $urandom;
         end
         if (!dbg_valid && $urandom_range(4) == 0) begin
            dbg_valid = 1;
            dbg_addr  = 5'($urandom_range(31));
            dbg_data  = $urandom;
         end
         wb_en   = ($urandom_range(1) == 1) && !(md_valid && starve == SMAX);
         wb_addr = 5'($urandom_range(31));
         if (pend[wb_addr]) wb_addr = 5'd0;
         wb_data = $urandom;
         md_issue      = ($urandom_range(2) == 0);
         md_issue_addr = 5'($urandom_range(31));
         rs_addr       = 5'($urandom_range(31));
         rt_addr       = 5'($urandom_range(31));
      end
      tick(); idle();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
